// File: rtl/mysystem_reset_pkg.sv
// rtl/mysystem_reset_pkg.sv - shared types and constants for the reset sequencer
package mysystem_reset_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    localparam logic [2:0] ADDR_CAUSE = 3'd0;
    localparam logic [2:0] ADDR_COUNT = 3'd1;
    localparam logic [2:0] ADDR_SWRST = 3'd2;

    localparam int CAUSE_W   = 4;
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_EXT = 2;
    localparam int CAUSE_SW  = 3;

    localparam logic [7:0] SWRST_KEY = 8'hA5;

endpackage

// File: rtl/mysystem_reset_sync.sv
// rtl/mysystem_reset_sync.sv - two-flop synchronizer with configurable reset value
module mysystem_reset_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both start at the "inactive" level so reset never looks like a request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mysystem_reset_ctrl.sv
// rtl/mysystem_reset_ctrl.sv - reset request merger, hold FSM, cause and event registers
module mysystem_reset_ctrl
    import mysystem_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wdt_resetrequest,
    input  logic        ext_reset_req_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        reset_out
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [15:0]          hold_q, hold_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [15:0]          count_q, count_d;
    logic [15:0]          readdata_q, readdata_d;

    logic ext_req_n_sync;
    logic ext_req;
    logic wr_en;
    logic sw_req;
    logic any_req;
    logic event_start;
    logic [CAUSE_W-1:0] cause_set;
    logic [CAUSE_W-1:0] cause_clr;
    logic unused_wdata;

    mysystem_reset_sync #(
        .RESET_VAL (1'b1)
    ) u_ext_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (ext_reset_req_n),
        .q_o     (ext_req_n_sync)
    );

    assign ext_req = ~ext_req_n_sync;
    assign wr_en   = chipselect & ~write_n;
    assign sw_req  = wr_en && (address == ADDR_SWRST) &&
                     (writedata[15:8] == SWRST_KEY) && writedata[0];
    assign any_req = wdt_resetrequest | ext_req | sw_req;

    assign unused_wdata = ^writedata[7:4];

    // State and hold counter; power-on reset parks the FSM in ASSERT with a full hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ASSERT;
            hold_q  <= HOLD_LOAD;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: requests during ASSERT/WAIT_REL never reload the hold counter.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        event_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ASSERT;
                    hold_d      = HOLD_LOAD;
                    event_start = 1'b1;
                end
            end
            ASSERT: begin
                if (hold_q == 16'd0) begin
                    state_d = any_req ? WAIT_REL : IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            WAIT_REL: begin
                if (!any_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = ASSERT;
                hold_d  = HOLD_LOAD;
            end
        endcase
    end

    assign reset_out = (state_q != IDLE);

    // Cause and counter next values: set beats write-1-to-clear, increment beats clear only as a 1.
    always_comb begin
        cause_set                = '0;
        cause_set[CAUSE_WDT]     = wdt_resetrequest;
        cause_set[CAUSE_EXT]     = ext_req;
        cause_set[CAUSE_SW]      = sw_req;
        cause_clr                = '0;
        if (wr_en && (address == ADDR_CAUSE)) begin
            cause_clr = writedata[CAUSE_W-1:0];
        end
        cause_d = (cause_q & ~cause_clr) | cause_set;

        count_d = count_q;
        if (wr_en && (address == ADDR_COUNT)) begin
            count_d = event_start ? 16'd1 : 16'd0;
        end else if (event_start && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Cause and event registers; only power-on reset clears them, not reset_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q            <= '0;
            cause_q[CAUSE_POR] <= 1'b1;
            count_q            <= 16'd0;
        end else begin
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Read mux, sampled unconditionally every cycle.
    always_comb begin
        readdata_d = 16'd0;
        case (address)
            ADDR_CAUSE: readdata_d = {{(16 - CAUSE_W){1'b0}}, cause_q};
            ADDR_COUNT: readdata_d = count_q;
            default:    readdata_d = 16'd0;
        endcase
    end

    // Registered read data gives a fixed one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= 16'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
